// File: rtl/id_fifo_decode_if.sv
// Fetch-to-issue bundle for id_fifo_decode: IF push side, regfile read ports,
// ID/EX issue side and status counters.
//   master : environment (IF stage, regfile, ID/EX, flush source)
//   slave  : the decode queue itself
interface id_fifo_decode_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
);
  localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

  // IF push side
  logic             in_valid_i;
  logic             in_ready_o;
  logic [XLEN-1:0]  in_pc_i;
  logic [31:0]      in_inst_i;
  logic             flush_i;

  // regfile read ports
  logic             reg1_read_o;
  logic [4:0]       reg1_addr_o;
  logic [XLEN-1:0]  reg1_data_i;
  logic             reg1_suc;
  logic             reg2_read_o;
  logic [4:0]       reg2_addr_o;
  logic [XLEN-1:0]  reg2_data_i;
  logic             reg2_suc;

  // ID/EX issue side
  logic             issue_valid_o;
  logic             issue_ready_i;
  logic [XLEN-1:0]  pc_o;
  logic [6:0]       aluop_o;
  logic [2:0]       alufunct3_o;
  logic [6:0]       alufunct7_o;
  logic [XLEN-1:0]  reg1_o;
  logic [XLEN-1:0]  reg2_o;
  logic [XLEN-1:0]  imm_o;
  logic             wreg_o;
  logic [4:0]       wd_o;

  // redirect and status
  logic             jump_o;
  logic [XLEN-1:0]  jpc_o;
  logic [OCC_W-1:0] count_o;
  logic [CNT_W-1:0] stall_cnt_o;

  modport master (
    output in_valid_i, in_pc_i, in_inst_i, flush_i,
           reg1_data_i, reg1_suc, reg2_data_i, reg2_suc, issue_ready_i,
    input  in_ready_o, reg1_read_o, reg1_addr_o, reg2_read_o, reg2_addr_o,
           issue_valid_o, pc_o, aluop_o, alufunct3_o, alufunct7_o,
           reg1_o, reg2_o, imm_o, wreg_o, wd_o,
           jump_o, jpc_o, count_o, stall_cnt_o
  );

  modport slave (
    input  in_valid_i, in_pc_i, in_inst_i, flush_i,
           reg1_data_i, reg1_suc, reg2_data_i, reg2_suc, issue_ready_i,
    output in_ready_o, reg1_read_o, reg1_addr_o, reg2_read_o, reg2_addr_o,
           issue_valid_o, pc_o, aluop_o, alufunct3_o, alufunct7_o,
           reg1_o, reg2_o, imm_o, wreg_o, wd_o,
           jump_o, jpc_o, count_o, stall_cnt_o
  );
endinterface

// File: rtl/id_fifo_decode.sv
// Queued decode stage between IF and ID/EX. Buffers {pc, inst} pairs in a
// DEPTH-entry ring, decodes the head combinationally (RV32I formats), reads
// operands through the regfile ports and issues under valid/ready. JAL, JALR
// and taken branches redirect fetch in the pop cycle and discard the queue.
// Ports:
//   clk, rst  : clock, asynchronous active-low reset
//   bus       : id_fifo_decode_if slave (push, regfile, issue, redirect, status)
module id_fifo_decode #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  id_fifo_decode_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_e;

  logic [XLEN-1:0]  pc_q   [DEPTH];
  logic [XLEN-1:0]  pc_d   [DEPTH];
  logic [31:0]      inst_q [DEPTH];
  logic [31:0]      inst_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [OCC_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic            empty, push, pop, kill, ops_ready, issue_valid, jump;
  logic            rd1, rd2, wreg, br_cond, xfer;
  logic [31:0]     hd_inst, imm32;
  logic [6:0]      opcode;
  logic [XLEN-1:0] hd_pc, imm, target, jalr_sum;
  fmt_e            fmt;

  assign empty       = (count_q == '0);
  assign ops_ready   = (!bus.reg1_read_o || bus.reg1_suc) && (!bus.reg2_read_o || bus.reg2_suc);
  assign issue_valid = !empty && ops_ready && !bus.flush_i;
  assign pop         = issue_valid && bus.issue_ready_i;
  assign jump        = pop && xfer;
  // Full-queue ready depends only on occupancy, never on a same-cycle pop.
  assign push        = bus.in_valid_i && bus.in_ready_o;
  assign kill        = bus.flush_i || jump;

  // Head decode: format, write-back flag and immediate.
  always_comb begin
    hd_inst = empty ? 32'h0 : inst_q[head_q];
    hd_pc   = empty ? '0 : pc_q[head_q];
    opcode  = hd_inst[6:0];
    fmt     = FMT_I;
    wreg    = 1'b1;
    case (opcode)
      OP_R:                     fmt = FMT_R;
      OP_IMM, OP_LOAD, OP_JALR: fmt = FMT_I;
      OP_STORE:  begin fmt = FMT_S; wreg = 1'b0; end
      OP_BRANCH: begin fmt = FMT_B; wreg = 1'b0; end
      OP_LUI, OP_AUIPC:         fmt = FMT_U;
      OP_JAL:                   fmt = FMT_J;
      default:                  fmt = FMT_I;   // unknown opcodes behave as I-type
    endcase
    imm32 = 32'h0;
    case (fmt)
      FMT_I: imm32 = {{20{hd_inst[31]}}, hd_inst[31:20]};
      FMT_S: imm32 = {{20{hd_inst[31]}}, hd_inst[31:25], hd_inst[11:7]};
      FMT_B: imm32 = {{20{hd_inst[31]}}, hd_inst[7], hd_inst[30:25], hd_inst[11:8], 1'b0};
      FMT_U: imm32 = {hd_inst[31:12], 12'h0};
      FMT_J: imm32 = {{12{hd_inst[31]}}, hd_inst[19:12], hd_inst[20], hd_inst[30:21], 1'b0};
      default: imm32 = 32'h0;
    endcase
    imm = XLEN'($signed(imm32));
    rd1 = (fmt != FMT_U) && (fmt != FMT_J);
    rd2 = (fmt == FMT_R) || (fmt == FMT_S) || (fmt == FMT_B);
  end

  // Regfile ports and issue bundle; everything is zero while the queue is empty.
  always_comb begin
    bus.reg1_read_o   = !empty && rd1;
    bus.reg2_read_o   = !empty && rd2;
    bus.reg1_addr_o   = bus.reg1_read_o ? hd_inst[19:15] : 5'd0;
    bus.reg2_addr_o   = bus.reg2_read_o ? hd_inst[24:20] : 5'd0;
    bus.reg1_o        = empty ? '0 : (rd1 ? bus.reg1_data_i : imm);
    bus.reg2_o        = empty ? '0 : (rd2 ? bus.reg2_data_i : imm);
    bus.imm_o         = empty ? '0 : imm;
    bus.pc_o          = hd_pc;
    bus.aluop_o       = opcode;
    bus.alufunct3_o   = (fmt == FMT_U || fmt == FMT_J) ? 3'd0 : hd_inst[14:12];
    bus.alufunct7_o   = (fmt == FMT_R) ? hd_inst[31:25] : 7'd0;
    bus.wreg_o        = !empty && wreg;
    bus.wd_o          = bus.wreg_o ? hd_inst[11:7] : 5'd0;
    bus.issue_valid_o = issue_valid;
    bus.in_ready_o    = (count_q < OCC_W'(DEPTH));
    bus.count_o       = count_q;
    bus.stall_cnt_o   = stall_q;
  end

  // Control transfer resolution; only acted on in the pop cycle.
  always_comb begin
    br_cond  = 1'b0;
    case (hd_inst[14:12])
      3'b000:  br_cond = (bus.reg1_data_i == bus.reg2_data_i);
      3'b001:  br_cond = (bus.reg1_data_i != bus.reg2_data_i);
      3'b100:  br_cond = ($signed(bus.reg1_data_i) <  $signed(bus.reg2_data_i));
      3'b101:  br_cond = ($signed(bus.reg1_data_i) >= $signed(bus.reg2_data_i));
      3'b110:  br_cond = (bus.reg1_data_i <  bus.reg2_data_i);
      3'b111:  br_cond = (bus.reg1_data_i >= bus.reg2_data_i);
      default: br_cond = 1'b0;
    endcase
    jalr_sum = bus.reg1_data_i + imm;
    xfer     = 1'b0;
    target   = hd_pc + imm;
    case (opcode)
      OP_JAL:    xfer = 1'b1;
      OP_JALR: begin
        xfer   = 1'b1;
        target = jalr_sum & {{(XLEN-1){1'b1}}, 1'b0};
      end
      OP_BRANCH: xfer = br_cond;
      default:   xfer = 1'b0;
    endcase
    bus.jump_o = jump;
    bus.jpc_o  = jump ? target : '0;
  end

  // Next-state: pointers, occupancy, storage and the saturating stall counter.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    stall_d = stall_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    if (kill) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        pc_d[tail_q]   = bus.in_pc_i;
        inst_d[tail_q] = bus.in_inst_i;
        tail_d         = tail_q + PTR_W'(1);
      end
      if (pop) head_d = head_q + PTR_W'(1);
      count_d = count_q + OCC_W'(push) - OCC_W'(pop);
    end
    if (!empty && !ops_ready && (stall_q != '1)) stall_d = stall_q + CNT_W'(1);
  end

  // Control state with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      stall_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      stall_q <= stall_d;
    end
  end

  // Entry storage; contents are only observed through occupancy, so no reset.
  always_ff @(posedge clk) begin
    pc_q   <= pc_d;
    inst_q <= inst_d;
  end
endmodule

// File: tb/tb_id_fifo_decode.sv
// Directed bench for id_fifo_decode with a scoreboard of expected issues.
module tb_id_fifo_decode;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 16;
  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_fifo_decode_if #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();
  id_fifo_decode #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  wd;
    logic        wreg;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [12:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  task automatic drive(input logic [31:0] pc, input logic [31:0] inst,
                       input logic [31:0] imm, input logic [4:0] wd, input logic wreg);
    bus.in_valid_i = 1'b1;
    bus.in_pc_i    = pc;
    bus.in_inst_i  = inst;
    cur = '{pc, imm, wd, wreg};
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  // Score the cycle's handshakes, then advance to just after the next edge.
  task automatic adv();
    exp_t e;
    if (bus.issue_valid_o && bus.issue_ready_i) begin
      chk("sb_entry_available", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_pc",   64'(bus.pc_o),   64'(e.pc));
        chk("sb_imm",  64'(bus.imm_o),  64'(e.imm));
        chk("sb_wd",   64'(bus.wd_o),   64'(e.wd));
        chk("sb_wreg", 64'(bus.wreg_o), 64'(e.wreg));
      end
    end
    if (bus.jump_o || bus.flush_i) exp_q.delete();
    else if (bus.in_valid_i && bus.in_ready_o) exp_q.push_back(cur);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    bus.in_valid_i = 1'b0; bus.in_pc_i = '0; bus.in_inst_i = '0; bus.flush_i = 1'b0;
    bus.reg1_data_i = '0; bus.reg1_suc = 1'b1; bus.reg2_data_i = '0; bus.reg2_suc = 1'b1;
    bus.issue_ready_i = 1'b0;
    #3;
    chk("rst_count",  64'(bus.count_o), 64'd0);
    chk("rst_ready",  64'(bus.in_ready_o), 64'd1);
    chk("rst_valid",  64'(bus.issue_valid_o), 64'd0);
    chk("rst_jump",   64'(bus.jump_o), 64'd0);
    chk("rst_jpc",    64'(bus.jpc_o), 64'd0);
    chk("rst_stall",  64'(bus.stall_cnt_o), 64'd0);
    chk("rst_wreg",   64'(bus.wreg_o), 64'd0);
    chk("rst_wd",     64'(bus.wd_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // ADDI x1,x0,5: issues the cycle after the push
    bus.issue_ready_i = 1'b1;
    drive(32'h0, enc_i(OP_IMM, 5'd1, 5'd0, 12'd5), 32'd5, 5'd1, 1'b1);
    settle(); chk("addi_no_same_cycle_issue", 64'(bus.issue_valid_o), 64'd0); adv();
    bus.in_valid_i = 1'b0;
    settle();
    chk("addi_valid", 64'(bus.issue_valid_o), 64'd1);
    chk("addi_imm",   64'(bus.imm_o), 64'd5);
    chk("addi_wd",    64'(bus.wd_o), 64'd1);
    chk("addi_rd1",   64'(bus.reg1_read_o), 64'd1);
    chk("addi_rd2",   64'(bus.reg2_read_o), 64'd0);
    chk("addi_reg2",  64'(bus.reg2_o), 64'd5);
    adv();
    settle(); chk("addi_count_back", 64'(bus.count_o), 64'd0); adv();

    // Fill to DEPTH with ID/EX stalled; fifth push refused, even alongside a pop
    bus.issue_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(32'(4 * k), enc_i(OP_IMM, 5'(k + 2), 5'd0, 12'(k + 1)), 32'(k + 1), 5'(k + 2), 1'b1);
      settle(); adv();
    end
    drive(32'h10, enc_i(OP_IMM, 5'd6, 5'd0, 12'd9), 32'd9, 5'd6, 1'b1);
    settle();
    chk("full_count", 64'(bus.count_o), 64'd4);
    chk("full_ready", 64'(bus.in_ready_o), 64'd0);
    chk("full_valid", 64'(bus.issue_valid_o), 64'd1);
    chk("full_head",  64'(bus.pc_o), 64'h0);
    adv();
    bus.issue_ready_i = 1'b1;
    settle();
    chk("full_pop_ready", 64'(bus.in_ready_o), 64'd0);
    chk("hold_head",      64'(bus.pc_o), 64'h0);
    adv();
    bus.in_valid_i = 1'b0;
    for (int k = 1; k < 4; k++) begin
      settle(); chk("drain_order_pc", 64'(bus.pc_o), 64'(4 * k)); adv();
    end
    settle(); chk("fifth_refused_count", 64'(bus.count_o), 64'd0); adv();

    // Stream 10 entries through with simultaneous push/pop (pointer wrap)
    for (int k = 0; k < 11; k++) begin
      if (k < 10) drive(32'h40 + 32'(4 * k), enc_i(OP_IMM, 5'(k + 1), 5'd0, 12'(3 * k)),
                        32'(3 * k), 5'(k + 1), 1'b1);
      else bus.in_valid_i = 1'b0;
      settle();
      if (k > 0) chk("stream_count", 64'(bus.count_o), 64'd1);
      adv();
    end
    settle(); chk("stream_drained", 64'(bus.count_o), 64'd0); adv();

    // BEQ taken with three entries behind it
    bus.issue_ready_i = 1'b0; bus.reg1_data_i = 32'd7; bus.reg2_data_i = 32'd7;
    drive(32'h20, enc_b(3'b000, 5'd1, 5'd2, 13'h010), 32'h10, 5'd0, 1'b0);
    settle(); adv();
    for (int k = 1; k < 4; k++) begin
      drive(32'h20 + 32'(4 * k), enc_i(OP_IMM, 5'd7, 5'd0, 12'(k)), 32'(k), 5'd7, 1'b1);
      settle(); adv();
    end
    bus.in_valid_i = 1'b0; bus.issue_ready_i = 1'b1;
    settle();
    chk("beq_count", 64'(bus.count_o), 64'd4);
    chk("beq_jump",  64'(bus.jump_o), 64'd1);
    chk("beq_jpc",   64'(bus.jpc_o), 64'h30);
    chk("beq_rs2",   64'(bus.reg2_addr_o), 64'd2);
    adv();
    settle();
    chk("beq_flushed", 64'(bus.count_o), 64'd0);
    chk("beq_jump_once", 64'(bus.jump_o), 64'd0);
    chk("beq_jpc_idle",  64'(bus.jpc_o), 64'd0);
    adv();

    // BNE not taken keeps the following entry
    bus.issue_ready_i = 1'b0;
    drive(32'h80, enc_b(3'b001, 5'd1, 5'd2, 13'h010), 32'h10, 5'd0, 1'b0); settle(); adv();
    drive(32'h84, enc_i(OP_IMM, 5'd8, 5'd0, 12'd1), 32'd1, 5'd8, 1'b1); settle(); adv();
    bus.in_valid_i = 1'b0; bus.issue_ready_i = 1'b1;
    settle(); chk("bne_nt_jump", 64'(bus.jump_o), 64'd0); chk("bne_nt_jpc", 64'(bus.jpc_o), 64'd0); adv();
    settle(); chk("bne_nt_next", 64'(bus.pc_o), 64'h84); adv();

    // BLTU not taken, BLT taken backwards (x1=-1, x2=1)
    bus.reg1_data_i = 32'hFFFF_FFFF; bus.reg2_data_i = 32'd1;
    drive(32'h94, enc_b(3'b110, 5'd1, 5'd2, 13'h010), 32'h10, 5'd0, 1'b0); settle(); adv();
    drive(32'h98, enc_b(3'b100, 5'd1, 5'd2, 13'h1FF0), 32'hFFFF_FFF0, 5'd0, 1'b0);
    settle(); chk("bltu_nt_jump", 64'(bus.jump_o), 64'd0); adv();
    bus.in_valid_i = 1'b0;
    settle(); chk("blt_jump", 64'(bus.jump_o), 64'd1); chk("blt_jpc", 64'(bus.jpc_o), 64'h88); adv();

    // JALR with a push in the pop cycle: push dropped
    bus.issue_ready_i = 1'b0; bus.reg1_data_i = 32'h1001;
    drive(32'h200, enc_i(OP_JALR, 5'd1, 5'd3, 12'd6), 32'd6, 5'd1, 1'b1); settle(); adv();
    drive(32'h204, enc_i(OP_IMM, 5'd9, 5'd0, 12'd2), 32'd2, 5'd9, 1'b1); settle(); adv();
    drive(32'h208, enc_i(OP_IMM, 5'd10, 5'd0, 12'd3), 32'd3, 5'd10, 1'b1);
    bus.issue_ready_i = 1'b1;
    settle();
    chk("jalr_jump", 64'(bus.jump_o), 64'd1);
    chk("jalr_jpc",  64'(bus.jpc_o), 64'h1006);
    chk("jalr_rs1",  64'(bus.reg1_addr_o), 64'd3);
    adv();
    bus.in_valid_i = 1'b0;
    settle(); chk("jalr_push_dropped", 64'(bus.count_o), 64'd0); adv();

    // JAL at 0x100, imm -8
    drive(32'h100, enc_j(5'd1, 21'h1FFFF8), 32'hFFFF_FFF8, 5'd1, 1'b1); settle(); adv();
    bus.in_valid_i = 1'b0;
    settle();
    chk("jal_jump", 64'(bus.jump_o), 64'd1);
    chk("jal_jpc",  64'(bus.jpc_o), 64'hF8);
    chk("jal_rd1",  64'(bus.reg1_read_o), 64'd0);
    adv();

    // R-type waiting on rs2 for three cycles
    bus.reg1_data_i = 32'd3; bus.reg2_data_i = 32'd4; bus.reg2_suc = 1'b0;
    drive(32'h300, enc_r(5'd3, 5'd1, 5'd2), 32'd0, 5'd3, 1'b1);
    settle(); chk("stall_start", 64'(bus.stall_cnt_o), 64'd0); adv();
    bus.in_valid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle(); chk("stall_no_issue", 64'(bus.issue_valid_o), 64'd0); adv();
    end
    bus.reg2_suc = 1'b1;
    settle();
    chk("stall_issue", 64'(bus.issue_valid_o), 64'd1);
    chk("stall_cnt3",  64'(bus.stall_cnt_o), 64'd3);
    chk("rtype_reg1",  64'(bus.reg1_o), 64'd3);
    chk("rtype_reg2",  64'(bus.reg2_o), 64'd4);
    adv();

    // Saturation of the stall counter
    bus.reg2_suc = 1'b0;
    drive(32'h304, enc_r(5'd4, 5'd1, 5'd2), 32'd0, 5'd4, 1'b1); settle(); adv();
    bus.in_valid_i = 1'b0;
    repeat ((1 << CNT_W) + 5) @(posedge clk);
    #1;
    chk("stall_sat", 64'(bus.stall_cnt_o), 64'hFFFF);
    @(posedge clk); #1;
    chk("stall_sat_hold", 64'(bus.stall_cnt_o), 64'hFFFF);
    bus.reg2_suc = 1'b1;
    settle(); chk("sat_then_issue", 64'(bus.issue_valid_o), 64'd1); adv();

    // Flush with three entries and a concurrent push
    bus.issue_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(32'h400 + 32'(4 * k), enc_i(OP_IMM, 5'd11, 5'd0, 12'(k)), 32'(k), 5'd11, 1'b1);
      settle(); adv();
    end
    drive(32'h40C, enc_i(OP_IMM, 5'd12, 5'd0, 12'd7), 32'd7, 5'd12, 1'b1);
    bus.flush_i = 1'b1; bus.issue_ready_i = 1'b1;
    settle();
    chk("flush_no_issue", 64'(bus.issue_valid_o), 64'd0);
    chk("flush_no_jump",  64'(bus.jump_o), 64'd0);
    adv();
    bus.flush_i = 1'b0; bus.in_valid_i = 1'b0;
    settle();
    chk("flush_count", 64'(bus.count_o), 64'd0);
    chk("flush_keeps_stall", 64'(bus.stall_cnt_o), 64'hFFFF);
    adv();

    // Asynchronous reset mid-queue, checked before any clock edge
    bus.issue_ready_i = 1'b0;
    drive(32'h500, enc_i(OP_IMM, 5'd13, 5'd0, 12'd1), 32'd1, 5'd13, 1'b1); settle(); adv();
    drive(32'h504, enc_i(OP_IMM, 5'd14, 5'd0, 12'd2), 32'd2, 5'd14, 1'b1); settle(); adv();
    bus.in_valid_i = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("arst_count", 64'(bus.count_o), 64'd0);
    chk("arst_valid", 64'(bus.issue_valid_o), 64'd0);
    chk("arst_stall", 64'(bus.stall_cnt_o), 64'd0);
    chk("arst_wd",    64'(bus.wd_o), 64'd0);
    chk("arst_pc",    64'(bus.pc_o), 64'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.issue_ready_i = 1'b1;
    drive(32'h600, enc_i(OP_IMM, 5'd15, 5'd0, 12'd4), 32'd4, 5'd15, 1'b1); settle(); adv();
    bus.in_valid_i = 1'b0;
    settle(); chk("post_rst_issue", 64'(bus.issue_valid_o), 64'd1); adv();
    chk("sb_empty_at_end", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/id_fifo_decode.md
Name: id_fifo_decode

Overview:
- Parametrised successor to the single-slot decode stage; sits between IF and ID/EX.
- Buffers fetched {pc, inst} pairs in a DEPTH-entry queue and decodes the head entry (R/I/S/B/U/J formats, same opcode map and immediate rules as the existing decoder).
- Reads operands through the regfile ports and issues to ID/EX under a valid/ready handshake.
- Resolves JAL/JALR/BRANCH at issue and flushes wrong-path entries.

Parameters:
XLEN, 32, data/address width
DEPTH, 4, queue entries; power of two, 2..16
CNT_W, 16, width of the saturating stall counter

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-low
in_valid_i  in  1  IF offers {in_pc_i, in_inst_i}
in_ready_o  out  1  queue can accept (count < DEPTH)
in_pc_i  in  XLEN  fetched pc
in_inst_i  in  32  fetched instruction
flush_i  in  1  external flush (e.g. exception); empties queue
reg1_read_o  out  1  rs1 read enable
reg1_addr_o  out  5  rs1 address (inst[19:15])
reg1_data_i  in  XLEN  rs1 data
reg1_suc  in  1  rs1 data valid (no hazard)
reg2_read_o  out  1  rs2 read enable
reg2_addr_o  out  5  rs2 address (inst[24:20])
reg2_data_i  in  XLEN  rs2 data
reg2_suc  in  1  rs2 data valid
issue_valid_o  out  1  head decoded and operands ready
issue_ready_i  in  1  ID/EX accepts
pc_o, aluop_o(7), alufunct3_o(3), alufunct7_o(7), reg1_o, reg2_o, imm_o, wreg_o(1), wd_o(5)  out  decoded fields of the head, same meaning as the existing ID/EX bundle
jump_o  out  1  redirect pc_reg this cycle
jpc_o  out  XLEN  redirect target
count_o  out  log2(DEPTH)+1  queue occupancy
stall_cnt_o  out  CNT_W  cycles the head waited on operands, saturating

Behaviour:
- Reset (rst=0, async): head/tail pointers=0, count_o=0, stall_cnt_o=0, in_ready_o=1, issue_valid_o=0, jump_o=0, jpc_o=0. All decoded outputs are zero when the queue is empty (NOP bundle, wreg_o=0, wd_o=0).
- Reset mid-operation discards all queued entries; no issue happens in the reset cycle.
- Push: in_valid_i && in_ready_o stores at tail. Pointers wrap modulo DEPTH.
- Pop: issue_valid_o && issue_ready_i.
- Simultaneous push and pop when full: in_ready_o stays 0. The push is not accepted even though a pop frees a slot; the ready path does not depend on the pop.
- Simultaneous push and pop otherwise: count unchanged, both pointers advance.
- Decode is combinational from the head entry; zero latency from head to issue when operands are ready. A push into an empty queue issues at the earliest on the next cycle.
- Read enables follow format: R/S/B read both; I reads rs1 only; U/J read none. Addresses are 0 when not read.
- Operand selection: reg1_o = reg1_data_i if read, else imm. reg2_o likewise.
- issue_valid_o = !empty && (!reg1_read_o || reg1_suc) && (!reg2_read_o || reg2_suc) && !flush_i.
- While issue_valid_o=1 and issue_ready_i=0, all issue outputs are held stable.
- stall_cnt_o increments (saturating at all-ones) every cycle the queue is non-empty but operands are not ready. It is not cleared by flush; only reset clears it.
- Control transfer, evaluated only on the pop cycle:
  - JAL: target pc+imm.
  - JALR: target (rs1+imm) with bit0 forced to 0; full XLEN add, wraps modulo 2^XLEN.
  - BRANCH: BEQ/BNE/BLT/BGE (signed)/BLTU/BGEU compare reg1_data_i against reg2_data_i; taken target pc+imm. Not-taken produces no jump.
- On a taken transfer: jump_o=1 and jpc_o=target, combinationally, in the pop cycle only. At the same edge all remaining entries are discarded and any push in that cycle is dropped. count_o=0 the next cycle.
- When jump_o=0, jpc_o=0.
- flush_i=1: forces issue_valid_o=0 and jump_o=0. At the edge the queue empties and the same-cycle push is dropped.
- Unknown opcodes decode as I-type with wreg_o=1 (legacy behaviour) and issue normally.

Test Plan:
- Reset release, push ADDI x1,x0,5 at pc 0x0, rs1 suc=1, issue_ready=1 -> next cycle issue_valid_o=1, imm_o=5, wd_o=1, wreg_o=1; count_o returns to 0.
- Push 4 instrs with issue_ready_i=0 -> count_o=4, in_ready_o=0. A 5th push is refused. Release ready -> 4 issues in order, pcs 0,4,8,C; pointer wraparound verified over 10 entries.
- BEQ at pc 0x20 with imm 0x10, x1=x2=7, 3 entries queued behind it -> pop cycle jump_o=1, jpc_o=0x30. Next cycle count_o=0; the push in the pop cycle is dropped.
- JALR rs1=0x1001, imm=0x6 -> jpc_o=0x1006. JAL at pc 0x100, imm -8 -> jpc_o=0xF8.
- R-type with reg2_suc=0 for 3 cycles -> issue_valid_o=0 throughout, stall_cnt_o +3, then issues. Separately, force stall for 2^CNT_W+5 cycles -> counter saturates at 0xFFFF.
- flush_i asserted with 3 entries and a concurrent push -> next cycle count_o=0, no issue or jump during flush. Asynchronous reset asserted mid-queue -> outputs zero immediately, without waiting for a clk edge.
